// File: rtl/ext_addrgen_v2_pkg.sv
// Shared definitions for the ext_addrgen_v2 transfer engine: FSM states,
// direction and element-size codes, and the default lane geometry.
package ext_addrgen_v2_pkg;

  localparam int STATES_W = 2;

  typedef enum logic [STATES_W-1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_EXT2INT = 2'd2,
    S_INT2EXT = 2'd3
  } state_t;

  localparam logic [1:0] DIR_EXT2INT = 2'b01;
  localparam logic [1:0] DIR_INT2EXT = 2'b10;

  localparam logic [1:0] ES_BYTE = 2'd0;
  localparam logic [1:0] ES_HALF = 2'd1;
  localparam logic [1:0] ES_WORD = 2'd2;
  localparam logic [1:0] ES_RSVD = 2'd3;

  // Default databus width and the number of address bits that select a byte lane.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANE_W = $clog2(DEF_DATA_W / 8);

  // The reserved size code behaves exactly like a word.
  function automatic logic [1:0] eff_size(input logic [1:0] es);
    return (es == ES_RSVD) ? ES_WORD : es;
  endfunction

  // Transfer state selected by a direction code (only called with a legal code).
  function automatic state_t dir_state(input logic [1:0] d);
    return (d == DIR_EXT2INT) ? S_EXT2INT : S_INT2EXT;
  endfunction

endpackage

// File: rtl/ext_addrgen_v2_gen.sv
// Delay / period / duty / iteration generator producing the element index.
// Configuration is captured on i_init; beats advance when enabled and not paused.
module ext_addrgen_v2_gen
  import ext_addrgen_v2_pkg::*;
#(
  parameter int AW = 11,
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_init,
  input  logic [AW-1:0] i_iterations,
  input  logic [PW-1:0] i_period,
  input  logic [PW-1:0] i_duty,
  input  logic [PW-1:0] i_delay,
  input  logic [AW-1:0] i_start,
  input  logic [AW-1:0] i_shift,
  input  logic [AW-1:0] i_incr,
  input  logic          i_dly_en,
  input  logic          i_en,
  input  logic          i_pause,
  output logic [AW-1:0] o_index,
  output logic          o_active,
  output logic          o_last,
  output logic          o_dly_done
);

  logic [AW-1:0] r_iter, r_shift, r_incr, r_i, r_index;
  logic [PW-1:0] r_per, r_duty, r_j, r_dly_cnt;
  logic          w_per_end;
  logic [AW-1:0] w_step;

  assign w_per_end  = (r_j == r_per - PW'(1));
  assign o_active   = (r_j < r_duty);
  assign o_last     = w_per_end && (r_i == r_iter - AW'(1));
  assign o_index    = r_index;
  assign o_dly_done = (r_dly_cnt <= PW'(1));

  // The period-end beat always takes incr (even when idle) plus shift, so a
  // period with trailing idle beats still steps past its last active element.
  assign w_step = ((o_active || w_per_end) ? r_incr : '0) + (w_per_end ? r_shift : '0);

  // Capture the loop configuration at the start of each run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iter  <= '0;
      r_per   <= '0;
      r_duty  <= '0;
      r_shift <= '0;
      r_incr  <= '0;
    end else if (i_init) begin
      r_iter  <= i_iterations;
      r_per   <= i_period;
      r_duty  <= i_duty;
      r_shift <= i_shift;
      r_incr  <= i_incr;
    end
  end

  // Beat/iteration counters, index accumulator and the initial delay countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_j       <= '0;
      r_i       <= '0;
      r_index   <= '0;
      r_dly_cnt <= '0;
    end else if (i_init) begin
      r_j       <= '0;
      r_i       <= '0;
      r_index   <= i_start;
      r_dly_cnt <= i_delay;
    end else begin
      if (i_dly_en && (r_dly_cnt != '0)) begin
        r_dly_cnt <= r_dly_cnt - PW'(1);
      end
      if (i_en && !i_pause) begin
        r_index <= r_index + w_step;
        if (w_per_end) begin
          r_j <= '0;
          r_i <= r_i + AW'(1);
        end else begin
          r_j <= r_j + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ext_addrgen_v2.sv
// External-memory transfer engine: moves elements between the databus and one
// internal memory port with size-dependent lane steering, abort and beat count.
module ext_addrgen_v2
  import ext_addrgen_v2_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int IO_ADDR_W    = 32,
  parameter int EXT_ADDR_W   = 11,
  parameter int EXT_PERIOD_W = 10,
  parameter int MEM_ADDR_W   = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    abort,
  input  logic                    int_cnt_en,
  output logic                    done,
  output logic [MEM_ADDR_W-1:0]   xfer_cnt,
  input  logic [IO_ADDR_W-1:0]    ext_addr,
  input  logic [MEM_ADDR_W-1:0]   int_addr,
  input  logic [1:0]              direction,
  input  logic [1:0]              elem_size,
  input  logic [EXT_ADDR_W-1:0]   iterations,
  input  logic [EXT_PERIOD_W-1:0] period,
  input  logic [EXT_PERIOD_W-1:0] duty,
  input  logic [EXT_PERIOD_W-1:0] delay,
  input  logic [EXT_ADDR_W-1:0]   start,
  input  logic [EXT_ADDR_W-1:0]   shift,
  input  logic [EXT_ADDR_W-1:0]   incr,
  input  logic                    databus_ready,
  output logic                    databus_valid,
  output logic [IO_ADDR_W-1:0]    databus_addr,
  input  logic [DATA_W-1:0]       databus_rdata,
  output logic [DATA_W-1:0]       databus_wdata,
  output logic [DATA_W/8-1:0]     databus_wstrb,
  output logic                    valid,
  output logic                    we,
  output logic [MEM_ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);

  state_t                  r_state, w_state_next;
  logic [IO_ADDR_W-1:0]    r_ext_addr;
  logic [MEM_ADDR_W-1:0]   r_int_addr, r_xfer_cnt, r_int_cnt;
  logic [1:0]              r_dir, r_esz;
  logic                    r_abort, r_stall;

  logic                    w_init, w_dir_ok, w_start_ok, w_in_xfer, w_beat_ok;
  logic                    w_hold, w_accept, w_adv;
  logic [EXT_ADDR_W-1:0]   w_index;
  logic                    w_active, w_last, w_dly_done;
  logic [1:0]              w_esz;
  logic [IO_ADDR_W-1:0]    w_byte_addr;
  logic [LANE_W-1:0]       w_align, w_lane;
  logic [STRB_W-1:0]       w_size_strb;
  logic [DATA_W-1:0]       w_size_mask;

  assign w_init     = (r_state == S_IDLE) && run;
  assign w_dir_ok   = (direction == DIR_EXT2INT) || (direction == DIR_INT2EXT);
  assign w_start_ok = w_init && !abort && w_dir_ok && (iterations != '0) && (period != '0);
  assign w_in_xfer  = (r_state == S_EXT2INT) || (r_state == S_INT2EXT);
  // After an abort only a request that was already stalled on the bus may be shown.
  assign w_beat_ok  = w_in_xfer && (!r_abort || r_stall);
  assign w_hold     = databus_valid && !databus_ready;
  assign w_accept   = databus_valid && databus_ready;
  assign w_adv      = w_beat_ok && !w_hold;

  ext_addrgen_v2_gen #(
    .AW (EXT_ADDR_W),
    .PW (EXT_PERIOD_W)
  ) u_gen (
    .clk          (clk),
    .rst          (rst),
    .i_init       (w_init),
    .i_iterations (iterations),
    .i_period     (period),
    .i_duty       (duty),
    .i_delay      (delay),
    .i_start      (start),
    .i_shift      (shift),
    .i_incr       (incr),
    .i_dly_en     (r_state == S_DELAY),
    .i_en         (w_beat_ok),
    .i_pause      (w_hold),
    .o_index      (w_index),
    .o_active     (w_active),
    .o_last       (w_last),
    .o_dly_done   (w_dly_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state: start, delay expiry, end of last beat, or abort once nothing is stalled.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = (delay != '0) ? S_DELAY : dir_state(direction);
      end
      S_DELAY: begin
        if (r_abort)         w_state_next = S_IDLE;
        else if (w_dly_done) w_state_next = dir_state(r_dir);
      end
      default: begin
        if ((r_abort && !w_hold) || (w_adv && w_last)) w_state_next = S_IDLE;
      end
    endcase
  end

  // Per-run configuration held for the whole transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext_addr <= '0;
      r_int_addr <= '0;
      r_dir      <= '0;
      r_esz      <= '0;
    end else if (w_init) begin
      r_ext_addr <= ext_addr;
      r_int_addr <= int_addr;
      r_dir      <= direction;
      r_esz      <= elem_size;
    end
  end

  // Beat counter and internal address counter; both restart on run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xfer_cnt <= '0;
      r_int_cnt  <= '0;
    end else if (w_init) begin
      r_xfer_cnt <= '0;
      r_int_cnt  <= '0;
    end else begin
      if (w_accept) r_xfer_cnt <= r_xfer_cnt + MEM_ADDR_W'(1);
      if (w_accept && ((r_state == S_EXT2INT) || int_cnt_en)) begin
        r_int_cnt <= r_int_cnt + MEM_ADDR_W'(1);
      end
    end
  end

  // Sticky abort while busy, and memory of a request left stalled last cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_abort <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_abort <= 1'b0;
      else if (abort)        r_abort <= 1'b1;
      r_stall <= w_hold;
    end
  end

  // Element size to lane alignment, byte strobe pattern and data mask.
  always_comb begin
    w_esz       = eff_size(r_esz);
    w_align     = '0;
    w_size_strb = STRB_W'(1);
    w_size_mask = DATA_W'(32'h0000_00FF);
    case (w_esz)
      ES_BYTE: begin
        w_align     = '0;
        w_size_strb = STRB_W'(1);
        w_size_mask = DATA_W'(32'h0000_00FF);
      end
      ES_HALF: begin
        w_align     = LANE_W'(1);
        w_size_strb = STRB_W'(3);
        w_size_mask = DATA_W'(32'h0000_FFFF);
      end
      default: begin
        w_align     = LANE_W'(3);
        w_size_strb = STRB_W'(15);
        w_size_mask = DATA_W'(32'hFFFF_FFFF);
      end
    endcase
  end

  assign w_byte_addr = r_ext_addr + (IO_ADDR_W'(w_index) << w_esz);
  assign w_lane      = w_byte_addr[LANE_W-1:0] & ~w_align;

  assign done          = (r_state == S_IDLE);
  assign xfer_cnt      = r_xfer_cnt;
  assign databus_valid = w_beat_ok && w_active;
  assign databus_addr  = w_byte_addr;
  assign databus_wdata = data_in << {w_lane, 3'b000};
  assign databus_wstrb = (databus_valid && (r_state == S_INT2EXT)) ? (w_size_strb << w_lane) : '0;
  assign valid         = (r_state == S_EXT2INT) ? w_accept : ((r_state == S_INT2EXT) && databus_valid);
  assign we            = (r_state == S_EXT2INT) && w_accept;
  assign addr          = r_int_addr + r_int_cnt;
  assign data_out      = (databus_rdata >> {w_lane, 3'b000}) & w_size_mask;

endmodule
